spike_count_readout: RTL
========================

// Module: spike_count_readout
// PURPOSE
//  Output readout stage fed directly by the layer-2 membrane-refresh neuron event stream.
//  Parses timestep frames (SOF 16'hF1FA ... indices ... EOF 16'hFAF1) and counts spikes per class neuron.
//  After TIMESTEPS frames it runs an argmax scan and emits the winning class and its spike count.
//  Live counters are shadow-copied at sample end, so the next sample's SOF may arrive the very next cycle.
// PARAMETERS
//  IDX_W        16        event word width; must match upstream neuron bus width
//  NUM_CLASSES  10        number of counted neuron indices, 0..NUM_CLASSES-1
//  CLS_W        4         width of result_class; must satisfy 2^CLS_W >= NUM_CLASSES
//  CNT_W        4         spike counter width; counters saturate at 2^CNT_W-1
//  TIMESTEPS    8         frames (EOF markers) per sample
//  SOF_WORD     16'hF1FA  timestep-start marker
//  EOF_WORD     16'hFAF1  timestep-end marker
// PORTS
//  clk           in   1      clock
//  rstn          in   1      reset, asynchronous, active-low
//  neuron_in     in   IDX_W  event word: marker or neuron index
//  neuron_valid  in   1      neuron_in valid; no backpressure, every valid word must be consumed
//  result_class  out  CLS_W  winning class index; held until the next result
//  result_count  out  CNT_W  spike count of the winning class; held
//  result_valid  out  1      1-cycle pulse when result_* update
//  busy          out  1      high while the argmax scan runs
//  frame_err     out  1      sticky protocol-error flag; cleared only by reset
//  overrun       out  1      sticky: a sample completed while the previous scan was still running
// BEHAVIOUR
//  Reset: all outputs 0, live/shadow counters 0, ts_cnt=0; frame FSM in IDLE, scan FSM in SCAN_IDLE.
//  Frame FSM, 2 states: IDLE (outside a frame) and COLLECT (inside a frame). Event classification per valid word:
//   - SOF in IDLE -> COLLECT.
//   - SOF in COLLECT -> frame_err=1; stay in COLLECT; counts are kept.
//   - EOF in COLLECT -> IDLE and ts_cnt++. EOF in IDLE -> frame_err=1; word ignored.
//   - Index < NUM_CLASSES in COLLECT -> cnt[idx]++, saturating. Index >= NUM_CLASSES -> dropped silently.
//   - Index in IDLE -> dropped and frame_err=1.
//  Sample end: the EOF that makes ts_cnt reach TIMESTEPS (EOF accepted in cycle N) does the following in one edge:
//   - copies live counters to the shadow bank, clears live counters, sets ts_cnt=0;
//   - starts the scan: busy=1 from N+1.
//   - If an index event for cnt[k] coincides with this EOF: impossible, since one word per cycle.
//  Scan FSM: SCAN_IDLE -> SCAN (NUM_CLASSES cycles, one shadow entry per cycle, i=0..NUM_CLASSES-1) -> SCAN_DONE (1 cycle).
//   - The running best is replaced only on strictly greater count, so ties resolve to the lowest index.
//   - All-zero counts give class 0, count 0.
//   - SCAN_DONE updates result_class/result_count and pulses result_valid in cycle N+NUM_CLASSES+1; busy drops the same cycle.
//  Latency, final EOF to result_valid: NUM_CLASSES+1 cycles (11 at defaults).
//  The frame FSM and live counting run concurrently with the scan; events during busy are counted normally.
//  Overrun: a sample end while busy=1 sets overrun=1, restarts the scan on the new shadow data, and the aborted result is never emitted.
//  Reset mid-operation: asynchronous clear to reset values; a partially counted sample is discarded.
// CONFIGURATION
//  SPIKE_READOUT_DROP_CNT_EN defined: adds output drop_count[15:0], reset 0.
//   - Increments on every dropped index, whether out of range or outside a frame; saturates at 16'hFFFF; never auto-clears.
//  SPIKE_READOUT_DROP_CNT_EN undefined: the port and its counter are absent; all other behaviour is identical.
// TESTING
//  1. 8 frames, frame 0 holds {3,3,7}, frames 1-7 hold {3} -> result_class=3, result_count=9 saturates? no: CNT_W=4 so 9; result_valid 11 cycles after 8th EOF.
//  2. Tie: 8 frames each with {2,5} -> result_class=2, result_count=8.
//  3. 8 empty frames (SOF/EOF only) -> result_class=0, result_count=0, frame_err=0.
//  4. Index 5 sent 20 times in one frame, plus indices 12 and 200, over 8 frames -> class 5, count 15 (saturated); 12 and 200 dropped; drop_count=2 with the macro defined.
//  5. Back-to-back: SOF the cycle after the final EOF, then 8 more frames -> two result_valid pulses, second result reflects only the second sample; no overrun.
//  6. Errors: index 4 before any SOF, EOF in IDLE, double SOF -> frame_err=1 sticky; then rstn low mid-frame -> all outputs 0, next clean sample scores correctly.

Source files
------------

// File: rtl/spike_count_readout.sv
// ============================================================================
// spike_count_readout
// ----------------------------------------------------------------------------
// Output readout stage for the layer-2 neuron event stream.
//
// The event stream is a sequence of timestep frames:
//     SOF_WORD, <neuron index>, <neuron index>, ..., EOF_WORD
// Spikes for neuron indices 0..NUM_CLASSES-1 are counted in saturating
// per-class counters. After TIMESTEPS frames the live counters are copied to
// a shadow bank and cleared, so the next sample can start on the following
// cycle. A scan then walks the shadow bank one entry per cycle. It reports the
// class with the highest count. Ties go to the lowest index.
//
// Optional feature (compile-time macro SPIKE_READOUT_DROP_CNT_EN):
//     when defined, adds the drop_count output. drop_count is a saturating
//     count of every dropped index word: out-of-range indices inside a frame,
//     and any index word outside a frame.
//
// Ports:
//     clk           in   1      clock
//     rstn          in   1      asynchronous, active-low reset
//     neuron_in     in   IDX_W  event word: SOF/EOF marker or neuron index
//     neuron_valid  in   1      neuron_in valid; one word per cycle, no stall
//     result_class  out  CLS_W  winning class index, held until next result
//     result_count  out  CNT_W  spike count of the winning class, held
//     result_valid  out  1      one-cycle pulse when result_* update
//     busy          out  1      high while the argmax scan runs
//     frame_err     out  1      sticky protocol-error flag
//     overrun       out  1      sticky: a sample ended while a scan was running
//     drop_count    out  16     (macro only) saturating dropped-index count
// ============================================================================
module spike_count_readout #(
    parameter int               IDX_W       = 16,
    parameter int               NUM_CLASSES = 10,
    parameter int               CLS_W       = 4,
    parameter int               CNT_W       = 4,
    parameter int               TIMESTEPS   = 8,
    parameter logic [IDX_W-1:0] SOF_WORD    = 16'hF1FA,
    parameter logic [IDX_W-1:0] EOF_WORD    = 16'hFAF1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] neuron_in,
    input  logic             neuron_valid,
    output logic [CLS_W-1:0] result_class,
    output logic [CNT_W-1:0] result_count,
    output logic             result_valid,
    output logic             busy,
    output logic             frame_err,
`ifdef SPIKE_READOUT_DROP_CNT_EN
    output logic [15:0]      drop_count,
`endif
    output logic             overrun
);

    // ts_cnt must be able to hold TIMESTEPS-1. The +1 keeps the width
    // non-zero when TIMESTEPS is 1.
    localparam int             TS_W    = $clog2(TIMESTEPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Word classification
    // ------------------------------------------------------------------------
    // A valid word is exactly one of: SOF marker, EOF marker, or index.
    // Marker values are never treated as indices, even though they are
    // numerically out of range.
    logic is_sof;
    logic is_eof;
    logic is_idx;
    logic idx_in_range;

    assign is_sof       = neuron_valid && (neuron_in == SOF_WORD);
    assign is_eof       = neuron_valid && (neuron_in == EOF_WORD);
    assign is_idx       = neuron_valid && !is_sof && !is_eof;
    assign idx_in_range = (neuron_in < IDX_W'(NUM_CLASSES));

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    typedef enum logic {
        IDLE,
        COLLECT
    } frame_state_t;

    frame_state_t frame_state;
    frame_state_t frame_next;

    logic             err_event;
    logic             count_hit;
    logic             eof_accept;
    logic             sample_end;
    logic [TS_W-1:0]  ts_cnt;

    // State register for the frame parser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_state <= IDLE;
        end else begin
            frame_state <= frame_next;
        end
    end

    // Next-state and event decode for the frame parser.
    // A stray SOF inside a frame is an error, but the frame carries on and
    // the counts collected so far are kept.
    // Index words outside a frame are dropped and flagged as errors.
    always_comb begin
        frame_next = frame_state;
        err_event  = 1'b0;
        count_hit  = 1'b0;
        eof_accept = 1'b0;
        case (frame_state)
            IDLE: begin
                if (is_sof) begin
                    frame_next = COLLECT;
                end else if (is_eof || is_idx) begin
                    err_event = 1'b1;
                end
            end
            COLLECT: begin
                if (is_sof) begin
                    err_event = 1'b1;
                end else if (is_eof) begin
                    frame_next = IDLE;
                    eof_accept = 1'b1;
                end else if (is_idx && idx_in_range) begin
                    count_hit = 1'b1;
                end
            end
            default: begin
                frame_next = IDLE;
            end
        endcase
    end

    // The EOF that completes the last timestep of a sample. It swaps the
    // banks and kicks off the scan, all on a single edge.
    assign sample_end = eof_accept && (ts_cnt == TS_W'(TIMESTEPS - 1));

    // Timestep counter. It counts accepted EOFs and wraps at the sample end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt <= '0;
        end else if (sample_end) begin
            ts_cnt <= '0;
        end else if (eof_accept) begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Sticky protocol error flag. Only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err <= 1'b0;
        end else if (err_event) begin
            frame_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Live and shadow counter banks
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] live_cnt   [NUM_CLASSES];
    logic [CNT_W-1:0] shadow_cnt [NUM_CLASSES];

    // Live counters collect spikes for the sample in progress.
    // A sample end and an index word can never land on the same edge, because
    // both need the single word slot. So clearing takes priority without
    // losing a count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                live_cnt[k] <= '0;
            end
        end else if (sample_end) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                live_cnt[k] <= '0;
            end
        end else if (count_hit) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if ((neuron_in == IDX_W'(k)) && (live_cnt[k] != CNT_MAX)) begin
                    live_cnt[k] <= live_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // The shadow bank freezes a finished sample for the scan. This frees the
    // live bank to accept the next sample right away.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                shadow_cnt[k] <= '0;
            end
        end else if (sample_end) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                shadow_cnt[k] <= live_cnt[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Argmax scan FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN,
        SCAN_DONE
    } scan_state_t;

    scan_state_t scan_state;
    scan_state_t scan_next;

    logic [CLS_W-1:0] scan_idx;
    logic [CLS_W-1:0] best_cls;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] scan_entry;
    logic [CLS_W-1:0] cand_cls;
    logic [CNT_W-1:0] cand_cnt;
    logic             scan_last;

    // State register for the scan sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_state <= SCAN_IDLE;
        end else begin
            scan_state <= scan_next;
        end
    end

    // Scan next-state logic. A new sample end always (re)starts the scan from
    // entry 0. If that happens mid-scan, the partial result is discarded and
    // never reaches the outputs. A sample end during SCAN_DONE is not an
    // overrun: that result is already on the outputs.
    always_comb begin
        scan_next = scan_state;
        case (scan_state)
            SCAN_IDLE: begin
                if (sample_end) begin
                    scan_next = SCAN;
                end
            end
            SCAN: begin
                if (sample_end) begin
                    scan_next = SCAN;
                end else if (scan_last) begin
                    scan_next = SCAN_DONE;
                end
            end
            SCAN_DONE: begin
                scan_next = sample_end ? SCAN : SCAN_IDLE;
            end
            default: begin
                scan_next = SCAN_IDLE;
            end
        endcase
    end

    assign busy         = (scan_state == SCAN);
    assign result_valid = (scan_state == SCAN_DONE);

    // Select the shadow entry under inspection. The explicit mux keeps the
    // read in range when NUM_CLASSES is not a power of two.
    always_comb begin
        scan_entry = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == CLS_W'(k)) begin
                scan_entry = shadow_cnt[k];
            end
        end
    end

    // Candidate best after considering the current entry. Only a strictly
    // greater count takes over, so the lowest index wins a tie. Starting the
    // running best at class 0 / count 0 makes an all-zero sample report 0/0.
    always_comb begin
        cand_cls = best_cls;
        cand_cnt = best_cnt;
        if (scan_entry > best_cnt) begin
            cand_cls = scan_idx;
            cand_cnt = scan_entry;
        end
    end

    assign scan_last = (scan_idx == CLS_W'(NUM_CLASSES - 1));

    // Scan datapath. The running best steps once per SCAN cycle. The final
    // SCAN cycle writes the result registers, so they already hold the new
    // value during the SCAN_DONE pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_idx     <= '0;
            best_cls     <= '0;
            best_cnt     <= '0;
            result_class <= '0;
            result_count <= '0;
        end else if (sample_end) begin
            scan_idx <= '0;
            best_cls <= '0;
            best_cnt <= '0;
        end else if (scan_state == SCAN) begin
            scan_idx <= scan_idx + CLS_W'(1);
            best_cls <= cand_cls;
            best_cnt <= cand_cnt;
            if (scan_last) begin
                result_class <= cand_cls;
                result_count <= cand_cnt;
            end
        end
    end

    // Sticky overrun flag. It is set when a sample completes while the
    // previous scan is still walking the shadow bank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (sample_end && busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef SPIKE_READOUT_DROP_CNT_EN
    // ------------------------------------------------------------------------
    // Dropped-index counter
    // ------------------------------------------------------------------------
    // Every index word that does not reach a counter is dropped. That covers
    // any index outside a frame, and out-of-range indices inside one.
    logic drop_hit;

    assign drop_hit = is_idx && ((frame_state == IDLE) || !idx_in_range);

    // Saturating drop counter. It never clears except on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count <= '0;
        end else if (drop_hit && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
